studio2_mem_arbiter: RTL and testbench
======================================

STUDIO2_MEM_ARBITER -- requirements
Module: studio2_mem_arbiter

Interface
REQ-001 SHALL have parameter DMA_BURST_MAX, default 8: max consecutive DMA grants while cpu_req is pending.
REQ-002 SHALL have parameter CART_BASE, default 12'h400: loader offset when ld_index != 0.
REQ-003 SHALL have port clk_sys, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have loader ports: ld_active in 1 (download in progress), ld_wr in 1, ld_index in 8, ld_addr in 12, ld_data in 8.
REQ-006 SHALL have CPU ports: cpu_req in 1, cpu_we in 1, cpu_addr in 16, cpu_wdata in 8, cpu_gnt out 1, cpu_rvalid out 1, cpu_rdata out 8.
REQ-007 SHALL have video DMA ports: dma_req in 1, dma_addr in 12, dma_gnt out 1, dma_rvalid out 1, dma_rdata out 8.
REQ-008 SHALL have memory ports: mem_addr out 12, mem_we out 1, mem_wdata out 8, mem_rdata in 8 (synchronous RAM, 1-cycle read latency).
REQ-009 SHALL have port wp_err, output, 1 bit: one-cycle pulse on a rejected CPU write.

Function
REQ-010 SHALL have two states: RUN and LOAD; LOAD whenever ld_active=1, RUN otherwise, switching the cycle after ld_active changes.
REQ-011 In LOAD, and in the cycle ld_active is first seen high, SHALL assert neither cpu_gnt nor dma_gnt.
REQ-012 In LOAD, each ld_wr cycle N SHALL drive mem_we=1, mem_addr=ld_addr+(ld_index!=0?CART_BASE:0) mod 4096, mem_wdata=ld_data at N+1.
REQ-013 In RUN, grants SHALL be combinational in cycle N, at most one per cycle; the granted access SHALL appear on mem_* at N+1.
REQ-014 Priority in RUN SHALL be DMA over CPU, except CPU wins once burst_cnt reaches DMA_BURST_MAX with cpu_req high.
REQ-015 burst_cnt SHALL increment on each DMA grant while cpu_req=1 and clear on any CPU grant or when cpu_req=0; it saturates at DMA_BURST_MAX.
REQ-016 Read data SHALL be returned at N+2 with rvalid for exactly one cycle, tagged to the requester granted at N; reads in flight when LOAD begins SHALL still complete.
REQ-017 CPU address decode: 0xC00-0xDFF SHALL map to 0x800-0x9FF (clear bit 10); all other addresses use cpu_addr[11:0].
REQ-018 CPU writes SHALL reach memory only for decoded addresses 0x800-0x9FF; any other granted write SHALL drive mem_we=0 and pulse wp_err at N+1.
REQ-019 A CPU read with cpu_addr[15:12] != 0 SHALL return cpu_rdata=8'hFF at N+2 (the memory cycle still occurs).
REQ-020 DMA SHALL be read-only, with mem_addr=dma_addr.
REQ-021 When no access is issued, mem_we SHALL be 0 and mem_addr SHALL hold its last value.

Reset
REQ-022 On reset_n low, asynchronously: state=RUN, burst_cnt=0, in-flight tags cleared, all gnt/rvalid/mem_we/wp_err=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, dma_rdata=0.
REQ-023 Reset mid-access SHALL drop in-flight reads without producing rvalid after reset release.

Structure
REQ-024 Owner tag enum (NONE/CPU/DMA), state enum, and address map constants (RAM_LO 12'h800, RAM_HI 12'h9FF, MIRROR_BIT 10) SHALL live in shared package studio2_pkg.
REQ-025 CPU address decode/protection SHALL be sub-module studio2_addr_decode (combinational: addr in, mapped addr, write_ok, open_bus out).

Verification
REQ-026 Loader: ld_active=1, ld_index=1, ld_wr at ld_addr=0x010 with data 0xA5 -> mem_we=1, mem_addr=0x410, mem_wdata=0xA5 one cycle later; no grants.
REQ-027 Both requesting continuously -> 8 DMA grants, then 1 CPU grant, repeating; rvalid exactly 2 cycles after each grant with correct owner.
REQ-028 CPU write 0x55 to 0x0C20 -> mem_addr=0x820, mem_we=1; CPU write to 0x0300 -> mem_we=0, wp_err pulse.
REQ-029 CPU read of 0x1800 -> cpu_rdata=0xFF, cpu_rvalid at N+2.
REQ-030 CPU read granted at N, ld_active rises at N+1 -> cpu_rvalid still at N+2; no grants until ld_active falls.
REQ-031 reset_n asserted the cycle after a DMA grant -> dma_rvalid never asserts; all outputs at reset values immediately.

Source files
------------

// File: rtl/studio2_pkg.sv
// Shared types and address-map constants for the Studio II memory arbiter.
package studio2_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;
  typedef enum logic {ST_RUN, ST_LOAD} state_t;

  localparam logic [11:0] RAM_LO     = 12'h800;
  localparam logic [11:0] RAM_HI     = 12'h9FF;
  localparam int          MIRROR_BIT = 10;

  typedef struct packed {
    logic [11:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } mem_cmd_t;

endpackage

// File: rtl/studio2_addr_decode.sv
// CPU address decode: folds the 0xC00-0xDFF mirror onto RAM and flags
// writable and open-bus addresses.
module studio2_addr_decode
  import studio2_pkg::*;
(
  input  logic [15:0] addr,
  output logic [11:0] mapped,
  output logic        write_ok,
  output logic        open_bus
);

  always_comb begin
    mapped = addr[11:0];
    if (addr[11:9] == 3'b110) mapped[MIRROR_BIT] = 1'b0;
    write_ok = (mapped >= RAM_LO) && (mapped <= RAM_HI);
    open_bus = |addr[15:12];
  end

endmodule

// File: rtl/studio2_mem_arbiter.sv
// Single-port RAM arbiter: loader writes during download, otherwise DMA/CPU
// arbitration with DMA burst limiting and a two-stage read-return pipeline.
module studio2_mem_arbiter
  import studio2_pkg::*;
#(
  parameter int          DMA_BURST_MAX = 8,
  parameter logic [11:0] CART_BASE     = 12'h400
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ld_active,
  input  logic        ld_wr,
  input  logic [7:0]  ld_index,
  input  logic [11:0] ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic [11:0] dma_addr,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [7:0]  dma_rdata,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        wp_err
);

  localparam int BW = $clog2(DMA_BURST_MAX + 1);

  state_t         state, state_nxt;
  logic [BW-1:0]  burst_cnt;
  logic           burst_full, run_ok;
  logic [11:0]    dec_addr;
  logic           dec_wok, dec_open;
  mem_cmd_t       cmd;
  owner_t         cmd_tag;
  logic           cmd_open, cmd_wp;
  owner_t         tag_pipe [1:2];
  logic [2:1]     open_pipe;

  studio2_addr_decode u_dec (
    .addr     (cpu_addr),
    .mapped   (dec_addr),
    .write_ok (dec_wok),
    .open_bus (dec_open)
  );

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = ld_active ? ST_LOAD : ST_RUN;
  end

  // Grants only while settled in RUN; the first ld_active cycle already blocks.
  always_comb begin
    burst_full = (burst_cnt == BW'(DMA_BURST_MAX));
    run_ok     = reset_n && (state == ST_RUN) && !ld_active;
    dma_gnt    = run_ok && dma_req && !(cpu_req && burst_full);
    cpu_gnt    = run_ok && cpu_req && !dma_gnt;
  end

  always_comb begin
    cmd      = '{addr: mem_addr, we: 1'b0, wdata: mem_wdata};
    cmd_tag  = OWN_NONE;
    cmd_open = 1'b0;
    cmd_wp   = 1'b0;
    if (ld_active && ld_wr) begin
      cmd.we    = 1'b1;
      cmd.addr  = ld_addr + ((ld_index != 8'd0) ? CART_BASE : 12'h000);
      cmd.wdata = ld_data;
    end else if (dma_gnt) begin
      cmd.addr = dma_addr;
      cmd_tag  = OWN_DMA;
    end else if (cpu_gnt) begin
      cmd.addr = dec_addr;
      if (cpu_we) begin
        cmd.we = dec_wok;
        cmd_wp = !dec_wok;
        if (dec_wok) cmd.wdata = cpu_wdata;
      end else begin
        cmd_tag  = OWN_CPU;
        cmd_open = dec_open;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wp_err    <= 1'b0;
      tag_pipe  <= '{OWN_NONE, OWN_NONE};
      open_pipe <= '0;
    end else begin
      if (cpu_gnt || !cpu_req)          burst_cnt <= '0;
      else if (dma_gnt && !burst_full)  burst_cnt <= burst_cnt + 1'b1;
      mem_addr     <= cmd.addr;
      mem_we       <= cmd.we;
      mem_wdata    <= cmd.wdata;
      wp_err       <= cmd_wp;
      // Read tags advance regardless of state so reads outlive a LOAD entry.
      tag_pipe[1]  <= cmd_tag;
      tag_pipe[2]  <= tag_pipe[1];
      open_pipe[1] <= cmd_open;
      open_pipe[2] <= open_pipe[1];
    end
  end

  // RAM data arrives in the third cycle, so the return path is a mux, not a flop.
  always_comb begin
    cpu_rvalid = (tag_pipe[2] == OWN_CPU);
    dma_rvalid = (tag_pipe[2] == OWN_DMA);
    cpu_rdata  = cpu_rvalid ? (open_pipe[2] ? 8'hFF : mem_rdata) : 8'h00;
    dma_rdata  = dma_rvalid ? mem_rdata : 8'h00;
  end

endmodule

// File: tb/tb_studio2_mem_arbiter.sv
// Randomized bench for studio2_mem_arbiter with a cycle-level reference model
// and a few directed scenarios pinned to literal values.
module tb_studio2_mem_arbiter;

  localparam int BURST = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ld_active, ld_wr;
  logic [7:0]  ld_index, ld_data;
  logic [11:0] ld_addr;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dma_req, dma_gnt, dma_rvalid;
  logic [11:0] dma_addr;
  logic [7:0]  dma_rdata;
  logic [11:0] mem_addr;
  logic        mem_we, wp_err;
  logic [7:0]  mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  studio2_mem_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ld_active(ld_active), .ld_wr(ld_wr), .ld_index(ld_index),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .wp_err(wp_err)
  );

  function automatic logic [7:0] init_byte(int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous RAM, one-cycle read latency.
  logic [7:0] ram [4096];
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = init_byte(i);
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk_sys);
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model: evaluated mid-cycle while inputs are stable.
  typedef struct { int due; bit is_cpu; logic [7:0] data; } rd_t;

  initial begin
    logic [7:0]  ref_mem [4096];
    rd_t         q[$];
    bit          m_load, m_we, m_wp, allow, e_dma, e_cpu, v_cpu, v_dma;
    int          m_burst, cyc, low, mapped;
    logic [11:0] m_addr;
    logic [7:0]  m_wdata, v_data;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
    m_load = 0; m_we = 0; m_wp = 0; m_burst = 0; m_addr = 0; m_wdata = 0; cyc = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        chk("rst_cpu_gnt", cpu_gnt, 0);     chk("rst_dma_gnt", dma_gnt, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0); chk("rst_dma_rvalid", dma_rvalid, 0);
        chk("rst_mem_we", mem_we, 0);       chk("rst_wp_err", wp_err, 0);
        chk("rst_mem_addr", mem_addr, 0);   chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0); chk("rst_dma_rdata", dma_rdata, 0);
        m_load = 0; m_we = 0; m_wp = 0; m_burst = 0; m_addr = 0; m_wdata = 0;
        q.delete();
      end else begin
        allow = !m_load && !ld_active;
        e_dma = allow && dma_req && !(cpu_req && m_burst >= BURST);
        e_cpu = allow && cpu_req && !e_dma;
        chk("dma_gnt", dma_gnt, e_dma);
        chk("cpu_gnt", cpu_gnt, e_cpu);
        chk("mem_we", mem_we, m_we);
        chk("wp_err", wp_err, m_wp);
        chk("mem_addr", mem_addr, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        v_cpu = 0; v_dma = 0; v_data = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
          v_cpu = q[0].is_cpu; v_dma = !q[0].is_cpu; v_data = q[0].data;
          void'(q.pop_front());
        end
        chk("cpu_rvalid", cpu_rvalid, v_cpu);
        chk("dma_rvalid", dma_rvalid, v_dma);
        if (v_cpu) chk("cpu_rdata", cpu_rdata, v_data);
        if (v_dma) chk("dma_rdata", dma_rdata, v_data);

        m_we = 0; m_wp = 0;
        if (ld_active && ld_wr) begin
          m_we = 1;
          m_addr = 12'((int'(ld_addr) + (ld_index != 0 ? 'h400 : 0)) % 4096);
          m_wdata = ld_data;
          ref_mem[m_addr] = ld_data;
        end else if (e_dma) begin
          m_addr = dma_addr;
          q.push_back('{cyc + 2, 1'b0, ref_mem[dma_addr]});
        end else if (e_cpu) begin
          low = int'(cpu_addr) % 4096;
          mapped = (low >= 'hC00 && low <= 'hDFF) ? low - 'h400 : low;
          m_addr = 12'(mapped);
          if (cpu_we) begin
            if (mapped >= 'h800 && mapped <= 'h9FF) begin
              m_we = 1; m_wdata = cpu_wdata; ref_mem[mapped] = cpu_wdata;
            end else m_wp = 1;
          end else
            q.push_back('{cyc + 2, 1'b1,
                          (cpu_addr >= 16'h1000) ? 8'hFF : ref_mem[mapped]});
        end
        if (e_cpu || !cpu_req) m_burst = 0;
        else if (e_dma && m_burst < BURST) m_burst++;
        m_load = ld_active;
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk_sys); #1;
  endtask

  task automatic idle();
    ld_active = 0; ld_wr = 0; cpu_req = 0; cpu_we = 0; dma_req = 0;
  endtask

  initial begin
    reset_n = 0; idle();
    ld_index = 0; ld_addr = 0; ld_data = 0;
    cpu_addr = 0; cpu_wdata = 0; dma_addr = 0;
    step(); step();
    chk("lit_reset_mem_addr", mem_addr, 12'h000);
    chk("lit_reset_gnt", {cpu_gnt, dma_gnt}, 2'b00);
    reset_n = 1;
    step();

    // Loader write into the cartridge window.
    ld_active = 1; step();
    ld_wr = 1; ld_index = 8'd1; ld_addr = 12'h010; ld_data = 8'hA5;
    cpu_req = 1; dma_req = 1; #1;
    chk("lit_ld_no_gnt", {cpu_gnt, dma_gnt}, 2'b00);
    step();
    chk("lit_ld_we", mem_we, 1'b1);
    chk("lit_ld_addr", mem_addr, 12'h410);
    chk("lit_ld_wdata", mem_wdata, 8'hA5);
    idle(); step(); step();

    // Mirror write accepted, low write rejected.
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0C20; cpu_wdata = 8'h55; #1;
    chk("lit_wr_gnt", cpu_gnt, 1'b1);
    step();
    chk("lit_wr_addr", mem_addr, 12'h820);
    chk("lit_wr_we", mem_we, 1'b1);
    cpu_addr = 16'h0300; step();
    chk("lit_wp_we", mem_we, 1'b0);
    chk("lit_wp_err", wp_err, 1'b1);
    idle(); step();
    chk("lit_wp_pulse", wp_err, 1'b0);

    // Open-bus read.
    cpu_req = 1; cpu_addr = 16'h1800; step();
    idle(); step();
    chk("lit_ob_rvalid", cpu_rvalid, 1'b1);
    chk("lit_ob_rdata", cpu_rdata, 8'hFF);
    step();

    // Sustained contention: 8 DMA then 1 CPU.
    cpu_req = 1; dma_req = 1; cpu_we = 0; cpu_addr = 16'h0850; dma_addr = 12'h123;
    for (int k = 0; k < 27; k++) begin
      #1;
      chk("lit_burst_pattern", {cpu_gnt, dma_gnt}, (k % 9 == 8) ? 2'b10 : 2'b01);
      step();
    end
    idle(); step(); step();

    // Read in flight across LOAD entry.
    cpu_req = 1; cpu_addr = 16'h0810; #1;
    chk("lit_ldr_gnt", cpu_gnt, 1'b1);
    step();
    ld_active = 1; dma_req = 1; #1;
    chk("lit_ldr_block", {cpu_gnt, dma_gnt}, 2'b00);
    step();
    chk("lit_ldr_rvalid", cpu_rvalid, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(); chk("lit_ldr_hold", {cpu_gnt, dma_gnt}, 2'b00);
    end
    ld_active = 0; #1;
    chk("lit_ldr_exit", {cpu_gnt, dma_gnt}, 2'b00);
    step(); #1;
    chk("lit_ldr_resume", dma_gnt, 1'b1);
    idle(); step(); step(); step();

    // Reset the cycle after a DMA grant.
    dma_req = 1; dma_addr = 12'h0A7; #1;
    chk("lit_rst_dma_gnt", dma_gnt, 1'b1);
    step();
    idle(); reset_n = 0; #1;
    chk("lit_rst_mem_addr", mem_addr, 12'h000);
    chk("lit_rst_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);
    step(); step();
    reset_n = 1;
    for (int k = 0; k < 4; k++) begin
      step(); chk("lit_rst_no_rvalid", dma_rvalid, 1'b0);
    end

    // Randomized traffic with occasional downloads.
    begin
      int ld_left = 0;
      for (int i = 0; i < 3000; i++) begin
        if (ld_left == 0 && $urandom_range(0, 99) == 0) ld_left = $urandom_range(3, 10);
        ld_active = (ld_left > 0);
        if (ld_left > 0) ld_left--;
        ld_wr    = ($urandom_range(0, 1) == 1);
        ld_index = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'd0;
        ld_addr  = 12'($urandom);
        ld_data  = 8'($urandom);
        cpu_req  = ($urandom_range(0, 9) < 7);
        cpu_we   = ($urandom_range(0, 9) < 3);
        cpu_wdata = 8'($urandom);
        case ($urandom_range(0, 3))
          0: cpu_addr = 16'h0800 + 16'($urandom_range(0, 'h1FF));
          1: cpu_addr = 16'h0C00 + 16'($urandom_range(0, 'h1FF));
          2: cpu_addr = 16'($urandom);
          default: cpu_addr = 16'($urandom_range(0, 'hFFF));
        endcase
        dma_req  = ($urandom_range(0, 9) < 6);
        dma_addr = 12'($urandom);
        step();
      end
    end
    idle(); step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
